// File: rtl/cam_pixel_pack_pkg.sv
// Shared types and constants for the camera pixel packer.
package cam_pixel_pack_pkg;

    // Width of one packed pixel lane in the FIFO word.
    localparam int BYTE_W = 8;

    // Frame-level packer state.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DROP   = 2'd2
    } state_e;

endpackage

// File: rtl/cam_pixel_pack.sv
// cam_pixel_pack: truncates a one-pixel-per-clock mono camera stream to 8 bits,
// packs DATA_WIDTH/8 pixels per word and writes the downstream FIFO. The camera
// cannot stall, so a word that meets a full FIFO is lost and the remainder of
// the frame is dropped to keep word alignment.
//
// Build option: define CAM_PIXEL_PACK_STATS_EN to build the per-frame word
// counter and the saturating dropped-frame counter; otherwise both outputs
// are tied to zero.
//
// Handshake: the FIFO side has no ready; fifo_wr_en_o is asserted only when a
// word is held (out_vld_q) and fifo_full_i is low in that same cycle. A held
// word is offered for exactly one cycle and is then either written or lost.
module cam_pixel_pack
    import cam_pixel_pack_pkg::*;
#(
    parameter int PIX_WIDTH  = 10,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  frame_start_i,
    input  logic                  line_end_i,
    input  logic                  pix_valid_i,
    input  logic [PIX_WIDTH-1:0]  pix_data_i,
    input  logic                  fifo_full_i,
    output logic                  fifo_wr_en_o,
    output logic [DATA_WIDTH-1:0] fifo_wdata_o,
    output logic                  frame_drop_o,
    output logic [CNT_WIDTH-1:0]  word_cnt_o,
    output logic [CNT_WIDTH-1:0]  drop_cnt_o
);

    localparam int PPW   = DATA_WIDTH / BYTE_W;
    localparam int IDX_W = (PPW > 1) ? $clog2(PPW) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PPW - 1);

    state_e                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_WIDTH-1:0] pack_q, pack_d;
    logic [DATA_WIDTH-1:0] out_q, out_d;
    logic                  out_vld_q, out_vld_d;

    logic [BYTE_W-1:0]     pix_byte;
    logic                  wr_fire;
    logic                  wr_lost;
    logic                  proc_en;
    int                    lane_base;

    // Keep the upper 8 bits of the pixel; the low bits are discarded.
    assign pix_byte = pix_data_i[PIX_WIDTH-1 -: BYTE_W];

    generate
        if (PIX_WIDTH > BYTE_W) begin : g_pix_lsb
            logic unused_pix_lsb;
            assign unused_pix_lsb = ^pix_data_i[PIX_WIDTH-BYTE_W-1:0];
        end
    endgenerate

    // A held word is either written this cycle or lost to a full FIFO.
    assign wr_fire = out_vld_q & ~fifo_full_i;
    assign wr_lost = out_vld_q &  fifo_full_i;

    assign fifo_wr_en_o = wr_fire;
    assign fifo_wdata_o = out_q;
    assign frame_drop_o = (state_q == DROP);

    // Next-state, packing and word hand-off logic.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        pack_d    = pack_q;
        out_d     = out_q;
        out_vld_d = 1'b0;
        proc_en   = 1'b0;
        lane_base = 0;

        if (frame_start_i) begin
            // New frame wins everywhere; a same-cycle pixel is pixel 0.
            state_d = ACTIVE;
            idx_d   = '0;
            pack_d  = '0;
            proc_en = 1'b1;
        end else if (wr_lost) begin
            // Lost word breaks alignment: drop the rest of this frame.
            state_d = DROP;
            idx_d   = '0;
            pack_d  = '0;
        end else if (state_q == ACTIVE) begin
            proc_en = 1'b1;
        end

        if (proc_en) begin
            if (pix_valid_i) begin
                lane_base = int'(idx_d) * BYTE_W;
                pack_d[lane_base +: BYTE_W] = pix_byte;
                if (idx_d == IDX_LAST) begin
                    out_d     = pack_d;
                    out_vld_d = 1'b1;
                    pack_d    = '0;
                    idx_d     = '0;
                end else begin
                    idx_d = idx_d + 1'b1;
                end
            end
            // Flush a partial word at end of line; unused lanes are already zero.
            if (line_end_i && (idx_d != '0)) begin
                out_d     = pack_d;
                out_vld_d = 1'b1;
                pack_d    = '0;
                idx_d     = '0;
            end
        end
    end

    // State, pack and output registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            pack_q    <= '0;
            out_q     <= '0;
            out_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            pack_q    <= pack_d;
            out_q     <= out_d;
            out_vld_q <= out_vld_d;
        end
    end

`ifdef CAM_PIXEL_PACK_STATS_EN
    logic [CNT_WIDTH-1:0] word_cnt_q, word_cnt_d;
    logic [CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;

    // Saturating words-written-this-frame and frames-dropped counters.
    always_comb begin
        word_cnt_d = word_cnt_q;
        drop_cnt_d = drop_cnt_q;
        if (frame_start_i) begin
            word_cnt_d = '0;
        end else if (wr_fire && (word_cnt_q != '1)) begin
            word_cnt_d = word_cnt_q + 1'b1;
        end
        if (wr_lost && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + 1'b1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            word_cnt_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            word_cnt_q <= word_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign word_cnt_o = word_cnt_q;
    assign drop_cnt_o = drop_cnt_q;
`else
    assign word_cnt_o = '0;
    assign drop_cnt_o = '0;
`endif

endmodule
